// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port arbiter for the 4-bank frame buffer
//
// Shares one RAM command port between a non-stallable capture write stream
// (absorbed by a small skid FIFO) and a req/ack readback requester.
//
// Ports:
//   iCLK, iRST_N            clock, synchronous active-low reset
//   iWR_EN/ADDR/DATA        capture write strobe, linear address, pixel
//   iRD_REQ/ADDR            read request (held until oRD_ACK), address
//   oRD_ACK                 one-cycle pulse: read command issued
//   oRD_DATA, oRD_DVAL      returned pixel and its one-cycle qualifier
//   oRAM_SEL/WE/ADDR/DATA   registered RAM command (one-hot bank select)
//   iRAM_Q                  bank read data, bank n at [n*DATA_W +: DATA_W]
//   oFIFO_LVL               skid FIFO occupancy
//   oOVF, iOVF_CLR          sticky write-overflow flag and its clear

module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int BANK_AW    = 17,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iWR_EN,
  input  logic [ADDR_W-1:0]   iWR_ADDR,
  input  logic [DATA_W-1:0]   iWR_DATA,
  input  logic                iRD_REQ,
  input  logic [ADDR_W-1:0]   iRD_ADDR,
  output logic                oRD_ACK,
  output logic [DATA_W-1:0]   oRD_DATA,
  output logic                oRD_DVAL,
  output logic [3:0]          oRAM_SEL,
  output logic                oRAM_WE,
  output logic [BANK_AW-1:0]  oRAM_ADDR,
  output logic [DATA_W-1:0]   oRAM_DATA,
  input  logic [4*DATA_W-1:0] iRAM_Q,
  output logic [2:0]          oFIFO_LVL,
  output logic                oOVF,
  input  logic                iOVF_CLR
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BIDX_W = ADDR_W - BANK_AW;
  localparam int ENT_W  = ADDR_W + DATA_W;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // Arbitration state
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Registered RAM command
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic [BANK_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ack_q, ack_d;
  logic [BIDX_W-1:0]  rd_bank_q, rd_bank_d;

  // Read-return pipeline: bank index travels alongside the RAM latency
  logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][BIDX_W-1:0]  pipe_bank_q, pipe_bank_d;
  logic [DATA_W-1:0]              rd_data_q, rd_data_d;
  logic                           dval_q, dval_d;

  // Combinational decisions
  logic              fifo_full, fifo_empty;
  logic              rd_ok, force_rd, grant_wr, grant_rd;
  logic              push_ok, ovf_evt;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] cmd_addr;

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    wait_d      = wait_q;
    sel_d       = 4'b0000;
    we_d        = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ack_d       = 1'b0;
    rd_bank_d   = rd_bank_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_bank_d = pipe_bank_q;
    rd_data_d   = rd_data_q;
    dval_d      = 1'b0;

    fifo_full  = (cnt_q == 3'(FIFO_DEPTH));
    fifo_empty = (cnt_q == 3'd0);
    head       = mem_q[rptr_q];

    // A request seen in its own ack cycle is the old one; ignore it.
    rd_ok    = iRD_REQ && !ack_q;
    force_rd = rd_ok && (wait_q >= WAIT_W'(MAX_WAIT - 1));
    grant_wr = !force_rd && !fifo_empty;
    grant_rd = rd_ok && (force_rd || fifo_empty);

    cmd_addr = grant_wr ? head[ENT_W-1:DATA_W] : iRD_ADDR;

    if (grant_wr || grant_rd) begin
      sel_d      = 4'b0001 << cmd_addr[ADDR_W-1:BANK_AW];
      ram_addr_d = cmd_addr[BANK_AW-1:0];
    end
    if (grant_wr) begin
      we_d       = 1'b1;
      ram_data_d = head[DATA_W-1:0];
      rptr_d     = rptr_q + PTR_W'(1);
    end
    if (grant_rd) begin
      ack_d     = 1'b1;
      rd_bank_d = iRD_ADDR[ADDR_W-1:BANK_AW];
    end

    // Starvation counter for the pending read
    if (!iRD_REQ || grant_rd) begin
      wait_d = '0;
    end else if (rd_ok && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    push_ok = iWR_EN && (!fifo_full || grant_wr);
    ovf_evt = iWR_EN && fifo_full && !grant_wr;
    if (push_ok) begin
      mem_d[wptr_q] = {iWR_ADDR, iWR_DATA};
      wptr_d        = wptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + 3'(push_ok) - 3'(grant_wr);
    ovf_d = ovf_evt || (ovf_q && !iOVF_CLR);

    // Stage 0 sees the command cycle; the last stage lines up with iRAM_Q.
    pipe_vld_d[0]  = ack_q;
    pipe_bank_d[0] = rd_bank_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_bank_d[i] = pipe_bank_q[i-1];
    end
    if (pipe_vld_q[RD_LAT-1]) begin
      dval_d    = 1'b1;
      rd_data_d = iRAM_Q[pipe_bank_q[RD_LAT-1]*DATA_W +: DATA_W];
    end
  end

  // FIFO payload needs no reset; the pointers define what is valid.
  always_ff @(posedge iCLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      wait_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ack_q       <= 1'b0;
      rd_bank_q   <= '0;
      pipe_vld_q  <= '0;
      pipe_bank_q <= '0;
      rd_data_q   <= '0;
      dval_q      <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ack_q       <= ack_d;
      rd_bank_q   <= rd_bank_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_bank_q <= pipe_bank_d;
      rd_data_q   <= rd_data_d;
      dval_q      <= dval_d;
    end
  end

  assign oRD_ACK   = ack_q;
  assign oRD_DATA  = rd_data_q;
  assign oRD_DVAL  = dval_q;
  assign oRAM_SEL  = sel_q;
  assign oRAM_WE   = we_q;
  assign oRAM_ADDR = ram_addr_q;
  assign oRAM_DATA = ram_data_q;
  assign oFIFO_LVL = cnt_q;
  assign oOVF      = ovf_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - self-checking bench for fb_port_arbiter
//
// Drives the arbiter against a small banked RAM model and compares every
// cycle with a transaction-level reference (queues of pending writes and
// pending read returns), plus hand-written vectors and corner sequences.

module tb_fb_port_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iWR_EN = 1'b0;
  logic [18:0] iWR_ADDR = '0;
  logic [11:0] iWR_DATA = '0;
  logic        iRD_REQ = 1'b0;
  logic [18:0] iRD_ADDR = '0;
  logic        iOVF_CLR = 1'b0;
  logic        oRD_ACK, oRD_DVAL, oRAM_WE, oOVF;
  logic [11:0] oRD_DATA, oRAM_DATA;
  logic [3:0]  oRAM_SEL;
  logic [16:0] oRAM_ADDR;
  logic [47:0] iRAM_Q;
  logic [2:0]  oFIFO_LVL;

  fb_port_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR),
    .oRD_ACK(oRD_ACK), .oRD_DATA(oRD_DATA), .oRD_DVAL(oRD_DVAL),
    .oRAM_SEL(oRAM_SEL), .oRAM_WE(oRAM_WE), .oRAM_ADDR(oRAM_ADDR),
    .oRAM_DATA(oRAM_DATA), .iRAM_Q(iRAM_Q),
    .oFIFO_LVL(oFIFO_LVL), .oOVF(oOVF), .iOVF_CLR(iOVF_CLR)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- banked RAM model (driven by the DUT) ----------------
  function automatic logic [11:0] mem_init(input logic [18:0] a);
    return 12'((a * 7) ^ (a >> 5) ^ 19'h5a5);
  endfunction

  logic [11:0] ram [logic [18:0]];
  logic [11:0] bq [4];
  assign iRAM_Q = {bq[3], bq[2], bq[1], bq[0]};

  function automatic logic [11:0] ram_rd(input logic [18:0] a);
    if (ram.exists(a)) return ram[a];
    return mem_init(a);
  endfunction

  always @(posedge iCLK) begin
    for (int n = 0; n < 4; n++) begin
      if (oRAM_SEL[n] && !oRAM_WE) bq[n] <= ram_rd({2'(n), oRAM_ADDR});
      else                         bq[n] <= 12'($urandom);
      if (oRAM_SEL[n] && oRAM_WE)  ram[{2'(n), oRAM_ADDR}] = oRAM_DATA;
    end
  end

  // ---------------- transaction-level reference ----------------
  typedef struct packed { logic [18:0] a; logic [11:0] d; } ent_t;
  typedef struct { int due; logic [11:0] v; } ret_t;
  ent_t mq[$];
  ret_t rq[$];
  logic [11:0] mmem [logic [18:0]];
  int  m_wait = 0;
  int  cyc = 0;
  logic [3:0]  e_sel = '0;
  logic        e_we = 0, e_ack = 0, e_dval = 0, e_ovf = 0;
  logic [16:0] e_addr = '0;
  logic [11:0] e_data = '0, e_rdd = '0;
  logic [2:0]  e_lvl = '0;

  function automatic logic [11:0] m_rd(input logic [18:0] a);
    if (mmem.exists(a)) return mmem[a];
    return mem_init(a);
  endfunction

  task automatic model_step();
    bit rd_ok, frc, gw, gr;
    ent_t e;
    ret_t r;
    cyc++;
    if (!iRST_N) begin
      mq.delete(); rq.delete(); m_wait = 0;
      e_sel = 0; e_we = 0; e_addr = 0; e_data = 0; e_ack = 0;
      e_dval = 0; e_rdd = 0; e_lvl = 0; e_ovf = 0;
    end else begin
      rd_ok = iRD_REQ && !e_ack;
      frc   = rd_ok && (m_wait >= MAX_WAIT - 1);
      gw    = !frc && (mq.size() > 0);
      gr    = rd_ok && (frc || mq.size() == 0);
      if (!iRD_REQ || gr) m_wait = 0;
      else if (rd_ok && m_wait < MAX_WAIT) m_wait++;
      e_ack = gr; e_we = gw; e_sel = 0;
      if (gw) begin
        e = mq.pop_front();
        mmem[e.a] = e.d;
        e_sel = 4'(1 << e.a[18:17]); e_addr = e.a[16:0]; e_data = e.d;
      end else if (gr) begin
        e_sel = 4'(1 << iRD_ADDR[18:17]); e_addr = iRD_ADDR[16:0];
        r.due = cyc + 2; r.v = m_rd(iRD_ADDR);
        rq.push_back(r);
      end
      if (iWR_EN) begin
        if (mq.size() < DEPTH) mq.push_back({iWR_ADDR, iWR_DATA});
        else e_ovf = 1;
      end else if (iOVF_CLR) e_ovf = 0;
      if (iWR_EN && iOVF_CLR && mq.size() < DEPTH) e_ovf = 0;
      e_dval = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front(); e_dval = 1; e_rdd = r.v;
      end
      e_lvl = 3'(mq.size());
    end
  endtask

  int max_lvl = 0;

  task automatic cyc_step();
    @(posedge iCLK);
    model_step();
    #1;
    chk("ram_sel", oRAM_SEL, e_sel);
    chk("ram_we", oRAM_WE, e_we);
    if (e_sel != 0) chk("ram_addr", oRAM_ADDR, e_addr);
    chk("ram_data", oRAM_DATA, e_data);
    chk("rd_ack", oRD_ACK, e_ack);
    chk("rd_dval", oRD_DVAL, e_dval);
    chk("rd_data", oRD_DATA, e_rdd);
    chk("fifo_lvl", oFIFO_LVL, e_lvl);
    chk("ovf", oOVF, e_ovf);
    if (int'(oFIFO_LVL) > max_lvl) max_lvl = int'(oFIFO_LVL);
  endtask

  // ---------------- hand vectors ----------------
  typedef struct {
    logic rst_n; logic wr_en; logic [18:0] wr_addr; logic [11:0] wr_data;
    logic rd_req; logic [18:0] rd_addr; logic clr;
    logic [3:0] sel; logic we; logic [16:0] addr; logic [11:0] data;
    logic ack; logic dval; logic [11:0] rdd; logic [2:0] lvl; logic ovf;
  } vec_t;
  vec_t tv [13];

  int lat, n_req, n_ack, n_wi, n_wo, wcnt;
  bit found, clr_now;

  task automatic new_req();
    iRD_REQ = 1'b1; iRD_ADDR = 19'($urandom); n_req++; lat = 0;
  endtask

  initial begin
    //          rst wr waddr     wdata   rq raddr     clr sel    we addr  data    ack dv rdd     lvl ovf
    tv[0]  = '{0, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   0, 0};
    tv[1]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   0, 0};
    tv[2]  = '{1, 1, 19'h40005, 12'hABC,0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   1, 0};
    tv[3]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h4, 1, 17'h5, 12'hABC, 0, 0, 12'h0,   0, 0};
    tv[4]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'hABC, 0, 0, 12'h0,   0, 0};
    tv[5]  = '{1, 0, 19'h0,     12'h0,  1, 19'h60003, 0, 4'h8, 0, 17'h3, 12'hABC, 1, 0, 12'h0,   0, 0};
    tv[6]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'hABC, 0, 0, 12'h0,   0, 0};
    tv[7]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'hABC, 0, 1, 12'h123, 0, 0};
    tv[8]  = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'hABC, 0, 0, 12'h123, 0, 0};
    tv[9]  = '{1, 0, 19'h0,     12'h0,  1, 19'h00010, 0, 4'h1, 0, 17'h10,12'hABC, 1, 0, 12'h123, 0, 0};
    tv[10] = '{0, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   0, 0};
    tv[11] = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   0, 0};
    tv[12] = '{1, 0, 19'h0,     12'h0,  0, 19'h0,     0, 4'h0, 0, 17'h0, 12'h0,   0, 0, 12'h0,   0, 0};

    ram[19'h60003]  = 12'h123;
    mmem[19'h60003] = 12'h123;

    for (int i = 0; i < 13; i++) begin
      iRST_N = tv[i].rst_n; iWR_EN = tv[i].wr_en; iWR_ADDR = tv[i].wr_addr;
      iWR_DATA = tv[i].wr_data; iRD_REQ = tv[i].rd_req; iRD_ADDR = tv[i].rd_addr;
      iOVF_CLR = tv[i].clr;
      cyc_step();
      chk($sformatf("tv%0d.sel", i), oRAM_SEL, tv[i].sel);
      chk($sformatf("tv%0d.we", i), oRAM_WE, tv[i].we);
      if (tv[i].sel != 0) chk($sformatf("tv%0d.addr", i), oRAM_ADDR, tv[i].addr);
      chk($sformatf("tv%0d.data", i), oRAM_DATA, tv[i].data);
      chk($sformatf("tv%0d.ack", i), oRD_ACK, tv[i].ack);
      chk($sformatf("tv%0d.dval", i), oRD_DVAL, tv[i].dval);
      chk($sformatf("tv%0d.rdd", i), oRD_DATA, tv[i].rdd);
      chk($sformatf("tv%0d.lvl", i), oFIFO_LVL, tv[i].lvl);
      chk($sformatf("tv%0d.ovf", i), oOVF, tv[i].ovf);
    end

    // Write priority, starvation bound and overflow: writes every cycle.
    max_lvl = 0; n_req = 0; wcnt = 0;
    new_req();
    for (int i = 0; i < 60; i++) begin
      iWR_EN = 1'b1; iWR_ADDR = 19'($urandom); iWR_DATA = 12'(wcnt++);
      cyc_step();
      lat++;
      if (oRD_ACK) begin
        chk("starve_latency", 32'(lat <= MAX_WAIT + 1), 32'd1);
        new_req();
      end
    end
    chk("fill_level", 32'(max_lvl), 32'(DEPTH));
    chk("ovf_set", oOVF, 1'b1);

    // Clear colliding with a fresh overflow: the overflow wins.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      iWR_EN = 1'b1; iWR_ADDR = 19'($urandom); iWR_DATA = 12'(wcnt++);
      clr_now = (mq.size() == DEPTH) && iRD_REQ && !e_ack && (m_wait >= MAX_WAIT - 1);
      iOVF_CLR = clr_now;
      cyc_step();
      if (clr_now) begin
        chk("ovf_clr_collision", oOVF, 1'b1);
        found = 1;
      end
      if (oRD_ACK) new_req();
    end
    chk("collision_found", 32'(found), 32'd1);
    iOVF_CLR = 1'b1; iWR_EN = 1'b0; iRD_REQ = 1'b0;
    cyc_step();
    chk("ovf_clr_alone", oOVF, 1'b0);
    iOVF_CLR = 1'b0;
    for (int i = 0; i < 12; i++) cyc_step();

    // Sustained capture: one write per two cycles, continuous reads.
    max_lvl = 0; n_req = 0; n_ack = 0; n_wi = 0; n_wo = 0;
    new_req();
    for (int i = 0; i < 2000; i++) begin
      iWR_EN = (i % 2 == 0);
      if (iWR_EN) begin
        iWR_ADDR = 19'($urandom); iWR_DATA = 12'($urandom); n_wi++;
      end
      cyc_step();
      lat++;
      if (oRAM_WE) n_wo++;
      if (oRD_ACK) begin
        n_ack++;
        if (lat > MAX_WAIT + 1) chk("sustain_latency", 32'(lat), 32'(MAX_WAIT + 1));
        new_req();
      end
    end
    iWR_EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc_step();
      if (oRAM_WE) n_wo++;
      if (oRD_ACK) begin n_ack++; iRD_REQ = 1'b0; end
    end
    chk("sustain_ovf", oOVF, 1'b0);
    chk("sustain_lvl_le2", 32'(max_lvl <= 2), 32'd1);
    chk("sustain_writes_out", 32'(n_wo), 32'(n_wi));
    chk("sustain_reads_acked", 32'(n_ack), 32'(n_req));

    // Randomized traffic, including overflow bursts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      iRST_N   = ($urandom_range(0, 399) != 0);
      iWR_EN   = ($urandom_range(0, 99) < 45);
      iWR_ADDR = 19'($urandom); iWR_DATA = 12'($urandom);
      iOVF_CLR = ($urandom_range(0, 99) < 5);
      cyc_step();
      if (!iRST_N) iRD_REQ = 1'b0;
      else if (oRD_ACK) begin
        if ($urandom_range(0, 1) != 0) new_req(); else iRD_REQ = 1'b0;
      end else if (!iRD_REQ && $urandom_range(0, 99) < 30) new_req();
    end
    iWR_EN = 1'b0; iRD_REQ = 1'b0; iOVF_CLR = 1'b0; iRST_N = 1'b1;
    for (int i = 0; i < 12; i++) cyc_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
